// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the two-port memory access controller.
// State values and port ids are fixed so external checkers can decode Dbg_State.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/mem_rr_arbiter.sv
// Two-way round-robin arbiter. On a tie the port opposite the last grant wins;
// the pointer only moves when a grant is actually issued (enable high).
module mem_rr_arbiter
    import mem_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       enable,
    output logic       grant_id,
    output logic       grant_valid
);

    logic last_q;

    always_comb begin
        grant_id = PORT_A;
        if (req == 2'b11) begin
            grant_id = ~last_q;
        end else if (req[1]) begin
            grant_id = PORT_B;
        end
    end

    assign grant_valid = enable & (|req);

    // Reset to B so that A wins the very first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= PORT_B;
        end else if (grant_valid) begin
            last_q <= grant_id;
        end
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares one single-ported 1-bit cell array between ports A and B.
// Each access runs IDLE -> ACCESS (one strobe cycle) -> DONE (ack until Req drops).
module mem_access_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int AW = 4,
    parameter int DW = 1
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          A_Req,
    input  logic          A_Wr,
    input  logic [AW-1:0] A_Addr,
    input  logic [DW-1:0] A_WData,
    output logic          A_Ack,
    output logic [DW-1:0] A_RData,
    input  logic          B_Req,
    input  logic          B_Wr,
    input  logic [AW-1:0] B_Addr,
    input  logic [DW-1:0] B_WData,
    output logic          B_Ack,
    output logic [DW-1:0] B_RData,
    output logic [AW-1:0] Mem_Addr,
    output logic [DW-1:0] Mem_D,
    output logic          Mem_Write,
    output logic          Mem_Read,
    input  logic [DW-1:0] Mem_Q,
    output logic          Busy,
    output logic [1:0]    Dbg_State
);

    state_t        state_q, state_d;
    logic          gid_q;
    logic          gnt_id, gnt_valid;
    logic          sel_wr, gid_req;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    mem_rr_arbiter u_arb (
        .clk         (Clk),
        .rst_n       (Rst_n),
        .req         ({B_Req, A_Req}),
        .enable      (state_q == IDLE),
        .grant_id    (gnt_id),
        .grant_valid (gnt_valid)
    );

    assign Dbg_State = state_q;

    always_comb begin
        sel_wr    = (gnt_id == PORT_B) ? B_Wr    : A_Wr;
        sel_addr  = (gnt_id == PORT_B) ? B_Addr  : A_Addr;
        sel_wdata = (gnt_id == PORT_B) ? B_WData : A_WData;
        gid_req   = (gid_q  == PORT_B) ? B_Req   : A_Req;
        state_d   = state_q;
        case (state_q)
            IDLE:    if (gnt_valid) state_d = ACCESS;
            ACCESS:  state_d = DONE;
            DONE:    if (!gid_req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Every array-facing and ack output is a flop loaded from the next state,
    // so strobes never glitch and only assert for the single ACCESS cycle.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            gid_q     <= PORT_A;
            Mem_Addr  <= '0;
            Mem_D     <= '0;
            Mem_Write <= 1'b0;
            Mem_Read  <= 1'b0;
            A_Ack     <= 1'b0;
            B_Ack     <= 1'b0;
            A_RData   <= '0;
            B_RData   <= '0;
            Busy      <= 1'b0;
        end else begin
            Mem_Write <= 1'b0;
            Mem_Read  <= 1'b0;
            if (state_q == IDLE && gnt_valid) begin
                gid_q     <= gnt_id;
                Mem_Addr  <= sel_addr;
                Mem_D     <= sel_wdata;
                Mem_Write <= sel_wr;
                Mem_Read  <= ~sel_wr;
            end
            // Mem_Read is high only during ACCESS, so this is the exiting edge.
            if (Mem_Read) begin
                if (gid_q == PORT_B) begin
                    B_RData <= Mem_Q;
                end else begin
                    A_RData <= Mem_Q;
                end
            end
            A_Ack <= (state_d == DONE) && (gid_q == PORT_A);
            B_Ack <= (state_d == DONE) && (gid_q == PORT_B);
            Busy  <= (state_d != IDLE);
        end
    end

endmodule
